// File: rtl/box_gen_pkg.sv
// Shared constants, colour tables and helpers for the multi-box pixel generator.
package box_gen_pkg;

    localparam int unsigned COLOR_W = 24;
    localparam int unsigned DIR_W   = 4;

    // move_dir bit positions
    localparam int unsigned DIR_RIGHT = 0;
    localparam int unsigned DIR_UP    = 1;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned DIR_LEFT  = 3;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [COLOR_W-1:0] DEF_COLOR [8] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
        24'hFF00FF, 24'h00FFFF, 24'hFF8000, 24'h8000FF
    };

    localparam logic [COLOR_W-1:0] ALT_COLOR [8] = '{
        24'h800000, 24'h008000, 24'h000080, 24'h808000,
        24'h800080, 24'h008080, 24'h804000, 24'h400080
    };

    localparam logic [COLOR_W-1:0] OFF_COLOR = 24'h101010;

    // Initial top-left corner of box i
    function automatic int unsigned x0(input int unsigned i, input int unsigned box_w);
        return 16 + i * (box_w + 16);
    endfunction

    function automatic int unsigned y0(input int unsigned i, input int unsigned box_h);
        return 16 + i * (box_h / 2);
    endfunction

endpackage

// File: rtl/box_motion.sv
// Position and bounce-direction state for one box, updated once per frame tick.
module box_motion
    import box_gen_pkg::*;
#(
    parameter int unsigned PIXEL_W     = 12,
    parameter int unsigned LINE_W      = 12,
    parameter int unsigned X_MAX       = 576,
    parameter int unsigned Y_MAX       = 432,
    parameter int unsigned X_INIT      = 16,
    parameter int unsigned Y_INIT      = 16,
    parameter bit          DY_INIT_NEG = 1'b0
) (
    input  logic               rfr_clk,
    input  logic               reset_n,
    input  logic               frame_tick_i,
    input  logic               move_en_i,
    input  mode_e              mode_i,
    input  logic [DIR_W-1:0]   move_dir_i,
    input  logic [PIXEL_W-1:0] step_i,
    output logic [PIXEL_W-1:0] x_o,
    output logic [LINE_W-1:0]  y_o
);

    localparam logic [PIXEL_W:0] X_LIM = (PIXEL_W+1)'(X_MAX);
    localparam logic [LINE_W:0]  Y_LIM = (LINE_W+1)'(Y_MAX);

    logic [PIXEL_W-1:0] x_q, x_d;
    logic [LINE_W-1:0]  y_q, y_d;
    logic               dx_neg_q, dx_neg_d;
    logic               dy_neg_q, dy_neg_d;

    // Boundary arithmetic one bit wider than the coordinate so nothing wraps
    logic [PIXEL_W:0]   x_step, x_inc;
    logic [LINE_W:0]    y_step, y_inc;
    logic [PIXEL_W-1:0] x_dec;
    logic [LINE_W-1:0]  y_dec;
    logic               x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;

    assign x_step   = {1'b0, step_i};
    assign y_step   = {1'b0, LINE_W'(step_i)};
    assign x_inc    = {1'b0, x_q} + x_step;
    assign y_inc    = {1'b0, y_q} + y_step;
    assign x_dec    = x_q - step_i;
    assign y_dec    = y_q - LINE_W'(step_i);
    assign x_hit_lo = ({1'b0, x_q} <= x_step);
    assign y_hit_lo = ({1'b0, y_q} <= y_step);
    assign x_hit_hi = (x_inc >= X_LIM);
    assign y_hit_hi = (y_inc >= Y_LIM);

    // Next position/direction: manual steering or bounce, only on an enabled tick
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        if (frame_tick_i && move_en_i) begin
            if (mode_i == MODE_MANUAL) begin
                if (move_dir_i[DIR_RIGHT]) begin
                    x_d = x_hit_hi ? X_LIM[PIXEL_W-1:0] : x_inc[PIXEL_W-1:0];
                end else if (move_dir_i[DIR_LEFT]) begin
                    x_d = x_hit_lo ? '0 : x_dec;
                end else if (move_dir_i[DIR_DOWN]) begin
                    y_d = y_hit_hi ? Y_LIM[LINE_W-1:0] : y_inc[LINE_W-1:0];
                end else if (move_dir_i[DIR_UP]) begin
                    y_d = y_hit_lo ? '0 : y_dec;
                end
            end else begin
                if (!dx_neg_q) begin
                    x_d      = x_hit_hi ? X_LIM[PIXEL_W-1:0] : x_inc[PIXEL_W-1:0];
                    dx_neg_d = x_hit_hi;
                end else begin
                    x_d      = x_hit_lo ? '0 : x_dec;
                    dx_neg_d = !x_hit_lo;
                end
                if (!dy_neg_q) begin
                    y_d      = y_hit_hi ? Y_LIM[LINE_W-1:0] : y_inc[LINE_W-1:0];
                    dy_neg_d = y_hit_hi;
                end else begin
                    y_d      = y_hit_lo ? '0 : y_dec;
                    dy_neg_d = !y_hit_lo;
                end
            end
        end
    end

    // Motion state register
    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= PIXEL_W'(X_INIT);
            y_q      <= LINE_W'(Y_INIT);
            dx_neg_q <= 1'b0;
            dy_neg_q <= DY_INIT_NEG;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/multi_box_pixel_gen.sv
// Draws NUM_BOXES layered rectangles; positions move once per synchronised v_sync rise.
module multi_box_pixel_gen
    import box_gen_pkg::*;
#(
    parameter int unsigned NUM_BOXES = 4,
    parameter int unsigned PIXEL_W   = 12,
    parameter int unsigned LINE_W    = 12,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned BOX_W     = 64,
    parameter int unsigned BOX_H     = 48,
    parameter int unsigned STEP_SLOW = 2,
    parameter int unsigned STEP_FAST = 8
) (
    input  logic                 rfr_clk,
    input  logic                 reset_n,
    input  logic                 video_on,
    input  logic [PIXEL_W-1:0]   pixel_cnt,
    input  logic [LINE_W-1:0]    line_cnt,
    input  logic                 v_sync,
    input  logic [NUM_BOXES-1:0] move_en,
    input  logic [NUM_BOXES-1:0] alt_color,
    input  logic                 bounce_en,
    input  logic [DIR_W-1:0]     move_dir,
    input  logic                 speed,
    output logic                 frame_tick,
    output logic [7:0]           p_red,
    output logic [7:0]           p_green,
    output logic [7:0]           p_blue
);

    localparam int unsigned X_MAX = H_ACTIVE - BOX_W;
    localparam int unsigned Y_MAX = V_ACTIVE - BOX_H;

    if (NUM_BOXES < 1 || NUM_BOXES > 8) begin : g_bad_count
        $error("NUM_BOXES must be 1..8");
    end

    logic                 vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q;
    logic [NUM_BOXES-1:0] hit_c, hit_q;
    logic                 vid_q;
    rgb_t                 color_c, rgb_q;
    logic [PIXEL_W-1:0]   step_c;
    mode_e                mode_c;
    logic [PIXEL_W-1:0]   box_x [NUM_BOXES];
    logic [LINE_W-1:0]    box_y [NUM_BOXES];

    assign step_c = speed ? PIXEL_W'(STEP_FAST) : PIXEL_W'(STEP_SLOW);
    assign mode_c = bounce_en ? MODE_BOUNCE : MODE_MANUAL;

    // v_sync synchroniser and rising-edge pulse
    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_meta_q    <= 1'b0;
            vs_sync_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            vs_meta_q    <= v_sync;
            vs_sync_q    <= vs_meta_q;
            vs_prev_q    <= vs_sync_q;
            frame_tick_q <= vs_sync_q & ~vs_prev_q;
        end
    end

    for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
        if (x0(i, BOX_W) > X_MAX || y0(i, BOX_H) > Y_MAX) begin : g_bad_init
            $error("initial box position out of range");
        end

        box_motion #(
            .PIXEL_W     (PIXEL_W),
            .LINE_W      (LINE_W),
            .X_MAX       (X_MAX),
            .Y_MAX       (Y_MAX),
            .X_INIT      (x0(i, BOX_W)),
            .Y_INIT      (y0(i, BOX_H)),
            .DY_INIT_NEG ((i % 2) == 1)
        ) u_motion (
            .rfr_clk      (rfr_clk),
            .reset_n      (reset_n),
            .frame_tick_i (frame_tick_q),
            .move_en_i    (move_en[i]),
            .mode_i       (mode_c),
            .move_dir_i   (move_dir),
            .step_i       (step_c),
            .x_o          (box_x[i]),
            .y_o          (box_y[i])
        );

        assign hit_c[i] = (pixel_cnt >= box_x[i]) &&
                          ({1'b0, pixel_cnt} < {1'b0, box_x[i]} + (PIXEL_W+1)'(BOX_W)) &&
                          (line_cnt >= box_y[i]) &&
                          ({1'b0, line_cnt} < {1'b0, box_y[i]} + (LINE_W+1)'(BOX_H));
    end

    // Lowest-index hit wins; otherwise background
    always_comb begin
        color_c = rgb_t'(OFF_COLOR);
        for (int i = int'(NUM_BOXES) - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                color_c = alt_color[i] ? rgb_t'(ALT_COLOR[i]) : rgb_t'(DEF_COLOR[i]);
            end
        end
    end

    // Two-stage pixel pipeline: hit flags, then gated colour
    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q <= '0;
            vid_q <= 1'b0;
            rgb_q <= '0;
        end else begin
            hit_q <= hit_c;
            vid_q <= video_on;
            rgb_q <= vid_q ? color_c : '0;
        end
    end

    assign frame_tick = frame_tick_q;
    assign p_red      = rgb_q.r;
    assign p_green    = rgb_q.g;
    assign p_blue     = rgb_q.b;

endmodule

// File: tb/tb_multi_box_pixel_gen.sv
// Randomised self-checking bench with a frame-level behavioural model of the boxes.
module tb_multi_box_pixel_gen;
    import box_gen_pkg::*;

    localparam int N    = 4;
    localparam int PW   = 12;
    localparam int LW   = 12;
    localparam int HA   = 640;
    localparam int VA   = 480;
    localparam int BW   = 64;
    localparam int BH   = 48;
    localparam int SS   = 2;
    localparam int SF   = 8;
    localparam int XMAX = HA - BW;
    localparam int YMAX = VA - BH;

    logic          rfr_clk, reset_n, video_on, v_sync, bounce_en, speed, frame_tick;
    logic [PW-1:0] pixel_cnt;
    logic [LW-1:0] line_cnt;
    logic [N-1:0]  move_en, alt_color;
    logic [3:0]    move_dir;
    logic [7:0]    p_red, p_green, p_blue;

    multi_box_pixel_gen #(
        .NUM_BOXES(N), .PIXEL_W(PW), .LINE_W(LW), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .BOX_W(BW), .BOX_H(BH), .STEP_SLOW(SS), .STEP_FAST(SF)
    ) dut (
        .rfr_clk(rfr_clk), .reset_n(reset_n), .video_on(video_on),
        .pixel_cnt(pixel_cnt), .line_cnt(line_cnt), .v_sync(v_sync),
        .move_en(move_en), .alt_color(alt_color), .bounce_en(bounce_en),
        .move_dir(move_dir), .speed(speed), .frame_tick(frame_tick),
        .p_red(p_red), .p_green(p_green), .p_blue(p_blue)
    );

    initial rfr_clk = 1'b0;
    always #5 rfr_clk = ~rfr_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: box corners and bounce directions (1 = moving negative)
    int mx [N];
    int my [N];
    bit mdxn [N];
    bit mdyn [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]   = 16 + i * (BW + 16);
            my[i]   = 16 + i * (BH / 2);
            mdxn[i] = 1'b0;
            mdyn[i] = (i % 2) == 1;
        end
    endfunction

    function automatic void bounce_axis(input int p, input bit neg, input int st, input int lim,
                                        output int p_n, output bit neg_n);
        int np;
        np    = neg ? p - st : p + st;
        p_n   = np;
        neg_n = neg;
        if (np >= lim) begin
            p_n = lim; neg_n = 1'b1;
        end else if (np <= 0) begin
            p_n = 0;   neg_n = 1'b0;
        end
    endfunction

    function automatic void model_tick();
        int st;
        int pn;
        bit nn;
        st = speed ? SF : SS;
        for (int i = 0; i < N; i++) begin
            if (move_en[i]) begin
                if (bounce_en) begin
                    bounce_axis(mx[i], mdxn[i], st, XMAX, pn, nn); mx[i] = pn; mdxn[i] = nn;
                    bounce_axis(my[i], mdyn[i], st, YMAX, pn, nn); my[i] = pn; mdyn[i] = nn;
                end else if (move_dir[0]) mx[i] = (mx[i] + st > XMAX) ? XMAX : mx[i] + st;
                else if (move_dir[3])     mx[i] = (mx[i] < st) ? 0 : mx[i] - st;
                else if (move_dir[2])     my[i] = (my[i] + st > YMAX) ? YMAX : my[i] + st;
                else if (move_dir[1])     my[i] = (my[i] < st) ? 0 : my[i] - st;
            end
        end
    endfunction

    function automatic logic [23:0] model_color(input int px, input int py, input bit vid);
        if (!vid) return 24'h0;
        for (int i = 0; i < N; i++) begin
            if (px >= mx[i] && px < mx[i] + BW && py >= my[i] && py < my[i] + BH)
                return alt_color[i] ? ALT_COLOR[i] : DEF_COLOR[i];
        end
        return OFF_COLOR;
    endfunction

    task automatic probe(input string tag, input int px, input int py, input bit vid);
        @(negedge rfr_clk);
        pixel_cnt = PW'(px);
        line_cnt  = LW'(py);
        video_on  = vid;
        @(posedge rfr_clk);
        @(posedge rfr_clk);
        #1;
        chk(tag, {8'h0, p_red, p_green, p_blue}, {8'h0, model_color(px, py, vid)});
    endtask

    // Probe the inside corners and the pixels just outside each edge of box i
    task automatic probe_box(input int i);
        int x, y;
        x = mx[i];
        y = my[i];
        probe("box_tl", x, y, 1'b1);
        probe("box_br", x + BW - 1, y + BH - 1, 1'b1);
        if (x > 0)       probe("box_left_out", x - 1, y, 1'b1);
        if (y > 0)       probe("box_top_out", x, y - 1, 1'b1);
        if (x + BW < HA) probe("box_right_out", x + BW, y, 1'b1);
        if (y + BH < VA) probe("box_bot_out", x, y + BH, 1'b1);
    endtask

    task automatic do_tick();
        @(negedge rfr_clk);
        v_sync = 1'b1;
        repeat (4) @(posedge rfr_clk);
        model_tick();
        @(negedge rfr_clk);
        v_sync = 1'b0;
        repeat (4) @(posedge rfr_clk);
    endtask

    task automatic pulse_reset();
        @(negedge rfr_clk);
        reset_n = 1'b0;
        @(negedge rfr_clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int tick_cnt;
        reset_n = 1'b0; video_on = 1'b0; v_sync = 1'b0; bounce_en = 1'b0; speed = 1'b0;
        pixel_cnt = '0; line_cnt = '0; move_en = '0; alt_color = '0; move_dir = '0;
        model_reset();
        repeat (3) @(posedge rfr_clk);
        #1;
        chk("reset_rgb", {8'h0, p_red, p_green, p_blue}, 32'h0);
        chk("reset_tick", {31'h0, frame_tick}, 32'h0);
        @(negedge rfr_clk);
        reset_n = 1'b1;

        // Initial positions of box 0 and box 1
        probe_box(0);
        probe_box(1);

        // Latency: a one-cycle hit appears exactly two cycles later
        probe("lat_miss", 15, 16, 1'b1);
        @(negedge rfr_clk);
        pixel_cnt = PW'(16);
        @(posedge rfr_clk); #1;
        chk("lat_c1", {8'h0, p_red, p_green, p_blue}, {8'h0, OFF_COLOR});
        @(negedge rfr_clk);
        pixel_cnt = PW'(15);
        @(posedge rfr_clk); #1;
        chk("lat_c2", {8'h0, p_red, p_green, p_blue}, {8'h0, DEF_COLOR[0]});
        @(posedge rfr_clk); #1;
        chk("lat_c3", {8'h0, p_red, p_green, p_blue}, {8'h0, OFF_COLOR});
        probe("video_off", 16, 16, 1'b0);

        // Asynchronous reset mid-line clears outputs immediately
        probe("pre_rst", 16, 16, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("rst_async", {8'h0, p_red, p_green, p_blue}, 32'h0);
        @(negedge rfr_clk);
        reset_n = 1'b1;
        model_reset();

        // v_sync held high for several frames: one tick, three clocks after the rise
        @(negedge rfr_clk);
        v_sync = 1'b1;
        tick_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge rfr_clk); #1;
            if (c <= 4) chk("tick_timing", {31'h0, frame_tick}, {31'h0, c == 3});
            tick_cnt += int'(frame_tick);
        end
        chk("tick_once", 32'(tick_cnt), 32'd1);
        model_tick();
        @(negedge rfr_clk);
        v_sync = 1'b0;
        repeat (4) @(posedge rfr_clk);
        probe_box(0);

        // Manual left clamp at 0, then right beats left
        move_en = 4'b0001; move_dir = 4'b1000; speed = 1'b0;
        repeat (8) do_tick();
        probe_box(0);
        do_tick();
        probe_box(0);
        move_dir = 4'b1001;
        do_tick();
        probe_box(0);

        // Box 1 fast left onto box 0; layering and alternate colour
        move_en = 4'b0010; move_dir = 4'b1000; speed = 1'b1;
        repeat (10) do_tick();
        probe_box(1);
        probe("overlap", 20, 50, 1'b1);
        alt_color = 4'b0001;
        probe("overlap_alt", 20, 50, 1'b1);
        alt_color = 4'b0000;

        // Bounce: box 0 reaches the right limit, then reverses; dy flipped earlier
        pulse_reset();
        bounce_en = 1'b1; move_en = 4'b0001; speed = 1'b1;
        repeat (70) do_tick();
        probe_box(0);
        do_tick();
        probe_box(0);

        // Random mode/direction/speed/enable mix
        for (int it = 0; it < 40; it++) begin
            move_en   = N'($urandom);
            move_dir  = 4'($urandom);
            speed     = 1'($urandom);
            bounce_en = 1'($urandom);
            alt_color = N'($urandom);
            repeat ($urandom_range(1, 3)) do_tick();
            for (int b = 0; b < N; b++) probe_box(b);
            for (int k = 0; k < 3; k++)
                probe("rand_pix", int'($urandom_range(0, HA - 1)), int'($urandom_range(0, VA - 1)),
                      1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
